// File: rtl/phy_reg_free_list_pkg.sv
// Shared rename-stage types and sizing for the physical-register free list.
// Commit-side struct mirrors the ROB commit fields so it maps field-for-field.
package phy_reg_free_list_pkg;
    localparam int PHY_REG_NUM  = 64;
    localparam int ARCH_REG_NUM = 32;
    localparam int ALLOC_WIDTH  = 2;
    localparam int FREE_WIDTH   = 2;
    localparam int DEPTH        = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int PW           = $clog2(PHY_REG_NUM);
    localparam int IW           = $clog2(DEPTH);

    typedef logic [PW-1:0] PhyRegIdx;
    typedef logic [IW:0]   FlPtr;

    typedef struct packed {
        logic [ALLOC_WIDTH-1:0] req;
        logic                   ready;
    } FreeListAllocSt;

    typedef struct packed {
        logic     valid;
        logic     rd_valid;
        PhyRegIdx old_preg;
    } FreeListCmtSt;
endpackage

// File: rtl/phy_reg_free_list_checker.sv
// Busy-vector consistency checker for the free list; dbg_err_o is registered and sticky.
// Flush rebuilds the speculative busy vector from the architectural copy.
module phy_reg_free_list_checker
    import phy_reg_free_list_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic                             alloc_fire_i,
    input  logic [ALLOC_WIDTH-1:0]           alloc_req_i,
    input  logic [ALLOC_WIDTH-1:0][PW-1:0]   alloc_preg_i,
    input  logic [FREE_WIDTH-1:0]            cmt_fire_i,
    input  logic [FREE_WIDTH-1:0][PW-1:0]    cmt_old_preg_i,
    input  logic [FREE_WIDTH-1:0][PW-1:0]    cmt_new_preg_i,
    output logic                             dbg_err_o
);
    localparam logic [PHY_REG_NUM-1:0] BUSY_RST = {{DEPTH{1'b0}}, {ARCH_REG_NUM{1'b1}}};

    logic [PHY_REG_NUM-1:0] busy_q, busy_d;
    logic [PHY_REG_NUM-1:0] arch_busy_q, arch_busy_d;
    logic                   err_q, err_d;

    always_comb begin
        busy_d      = busy_q;
        arch_busy_d = arch_busy_q;
        err_d       = err_q;
        // Retiring an instruction frees its old mapping and makes its new preg architectural.
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (cmt_fire_i[j]) begin
                if (cmt_old_preg_i[j] == '0 || !busy_q[cmt_old_preg_i[j]]) begin
                    err_d = 1'b1;
                end
                busy_d[cmt_old_preg_i[j]]      = 1'b0;
                arch_busy_d[cmt_old_preg_i[j]] = 1'b0;
                arch_busy_d[cmt_new_preg_i[j]] = 1'b1;
            end
        end
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (alloc_fire_i && alloc_req_i[i]) begin
                if (busy_q[alloc_preg_i[i]]) begin
                    err_d = 1'b1;
                end
                busy_d[alloc_preg_i[i]] = 1'b1;
            end
        end
        if (flush_i) begin
            busy_d = arch_busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= BUSY_RST;
            arch_busy_q <= BUSY_RST;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            arch_busy_q <= arch_busy_d;
            err_q       <= err_d;
        end
    end

    assign dbg_err_o = err_q;
endmodule

// File: rtl/phy_reg_free_list.sv
// Circular physical-register free list: zero-latency compacted allocation, in-order reclaim,
// one-cycle flush restore. Gnt only when a full group fits. FREELIST_CHECK_EN adds dbg_err_o.
module phy_reg_free_list
    import phy_reg_free_list_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [ALLOC_WIDTH-1:0]           alloc_req_i,
    input  logic                             alloc_ready_i,
    output logic                             alloc_gnt_o,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]   alloc_preg_o,
    input  logic [FREE_WIDTH-1:0]            cmt_valid_i,
    input  logic [FREE_WIDTH-1:0]            cmt_rd_valid_i,
    input  logic [FREE_WIDTH-1:0][PW-1:0]    cmt_old_preg_i,
    output logic [IW:0]                      free_cnt_o
`ifdef FREELIST_CHECK_EN
    ,
    output logic                             dbg_err_o
`endif
);
    PhyRegIdx entry_q [DEPTH];
    FlPtr     spec_head_q, spec_head_d;
    FlPtr     arch_head_q, arch_head_d;
    FlPtr     tail_q, tail_d;
    FlPtr     count_q, count_d;

    FreeListAllocSt                  alloc_s;
    FreeListCmtSt [FREE_WIDTH-1:0]   cmt_s;
    logic [FREE_WIDTH-1:0]           cmt_fire;
    logic [ALLOC_WIDTH-1:0][IW:0]    alloc_ofs;
    logic [ALLOC_WIDTH-1:0][IW:0]    alloc_ptr;
    logic [FREE_WIDTH-1:0][IW:0]     cmt_ofs;
    logic [FREE_WIDTH-1:0][IW:0]     cmt_wr_ptr;
    FlPtr                            alloc_total, cmt_total, alloc_n;
    logic                            alloc_fire;

    assign alloc_s = '{req: alloc_req_i, ready: alloc_ready_i};

    always_comb begin
        for (int j = 0; j < FREE_WIDTH; j++) begin
            cmt_s[j]    = '{valid: cmt_valid_i[j], rd_valid: cmt_rd_valid_i[j], old_preg: cmt_old_preg_i[j]};
            cmt_fire[j] = cmt_s[j].valid & cmt_s[j].rd_valid;
        end
    end

    // Prefix popcounts compact both the read and write sides onto consecutive entries.
    always_comb begin
        alloc_total = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_ofs[i] = alloc_total;
            alloc_ptr[i] = spec_head_q + alloc_total;
            alloc_total  = alloc_total + FlPtr'(alloc_s.req[i]);
        end
        cmt_total = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            cmt_ofs[j]    = cmt_total;
            cmt_wr_ptr[j] = tail_q + cmt_total;
            cmt_total     = cmt_total + FlPtr'(cmt_fire[j]);
        end
    end

    always_comb begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_preg_o[i] = entry_q[alloc_ptr[i][IW-1:0]];
        end
    end

    assign alloc_gnt_o = (count_q >= FlPtr'(ALLOC_WIDTH));
    assign alloc_fire  = alloc_gnt_o & alloc_s.ready & ~flush_i;
    assign alloc_n     = alloc_fire ? alloc_total : '0;
    assign free_cnt_o  = count_q;

    always_comb begin
        tail_d      = tail_q + cmt_total;
        arch_head_d = arch_head_q + cmt_total;
        if (flush_i) begin
            spec_head_d = arch_head_d;
            count_d     = FlPtr'(DEPTH);
        end else begin
            spec_head_d = spec_head_q + alloc_n;
            count_d     = count_q + cmt_total - alloc_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= FlPtr'(DEPTH);
            count_q     <= FlPtr'(DEPTH);
        end else begin
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PhyRegIdx'(ARCH_REG_NUM + i);
            end
        end else begin
            for (int j = 0; j < FREE_WIDTH; j++) begin
                if (cmt_fire[j]) begin
                    entry_q[cmt_wr_ptr[j][IW-1:0]] <= cmt_s[j].old_preg;
                end
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    // Tail and arch head share an index, so the slot being overwritten holds the retiring new preg.
    logic [FREE_WIDTH-1:0][PW-1:0] cmt_new_preg;
    logic [FREE_WIDTH-1:0][IW:0]   cmt_arch_ptr;

    always_comb begin
        for (int j = 0; j < FREE_WIDTH; j++) begin
            cmt_arch_ptr[j] = arch_head_q + cmt_ofs[j];
            cmt_new_preg[j] = entry_q[cmt_arch_ptr[j][IW-1:0]];
        end
    end

    phy_reg_free_list_checker u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .alloc_fire_i   (alloc_fire),
        .alloc_req_i    (alloc_s.req),
        .alloc_preg_i   (alloc_preg_o),
        .cmt_fire_i     (cmt_fire),
        .cmt_old_preg_i (cmt_old_preg_i),
        .cmt_new_preg_i (cmt_new_preg),
        .dbg_err_o      (dbg_err_o)
    );
`endif
endmodule

// File: tb/tb_phy_reg_free_list.sv
// Randomized and directed bench for phy_reg_free_list against a queue-based free-list model.
module tb_phy_reg_free_list;
    import phy_reg_free_list_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           flush_i;
    logic [ALLOC_WIDTH-1:0]         alloc_req_i;
    logic                           alloc_ready_i;
    logic                           alloc_gnt_o;
    logic [ALLOC_WIDTH-1:0][PW-1:0] alloc_preg_o;
    logic [FREE_WIDTH-1:0]          cmt_valid_i;
    logic [FREE_WIDTH-1:0]          cmt_rd_valid_i;
    logic [FREE_WIDTH-1:0][PW-1:0]  cmt_old_preg_i;
    logic [IW:0]                    free_cnt_o;
`ifdef FREELIST_CHECK_EN
    logic                           dbg_err_o;
`endif

    phy_reg_free_list dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .alloc_req_i    (alloc_req_i),
        .alloc_ready_i  (alloc_ready_i),
        .alloc_gnt_o    (alloc_gnt_o),
        .alloc_preg_o   (alloc_preg_o),
        .cmt_valid_i    (cmt_valid_i),
        .cmt_rd_valid_i (cmt_rd_valid_i),
        .cmt_old_preg_i (cmt_old_preg_i),
        .free_cnt_o     (free_cnt_o)
`ifdef FREELIST_CHECK_EN
        ,
        .dbg_err_o      (dbg_err_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: fl holds the DEPTH free-list entries in order from the architectural head;
    // spec_off is how many of them rename has speculatively handed out.
    int fl[$];
    int spec_off;
    int pool[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(ARCH_REG_NUM + i);
        spec_off = 0;
        pool.delete();
        for (int i = 1; i < ARCH_REG_NUM; i++) pool.push_back(i);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        flush_i        = 1'b0;
        alloc_req_i    = '0;
        alloc_ready_i  = 1'b0;
        cmt_valid_i    = '0;
        cmt_rd_valid_i = '0;
        cmt_old_preg_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [1:0] req, input logic rdy, input logic flv,
                        input logic [1:0] cv, input logic [1:0] crv, input int o0, input int o1);
        int ofs;
        int fired;
        int exp_cnt;
        bit exp_gnt;
        int olds[2];
        alloc_req_i       = req;
        alloc_ready_i     = rdy;
        flush_i           = flv;
        cmt_valid_i       = cv;
        cmt_rd_valid_i    = crv;
        cmt_old_preg_i[0] = o0[PW-1:0];
        cmt_old_preg_i[1] = o1[PW-1:0];
        @(negedge clk);
        exp_cnt = DEPTH - spec_off;
        exp_gnt = (exp_cnt >= ALLOC_WIDTH);
        check_eq("free_cnt", free_cnt_o, exp_cnt);
        check_eq("alloc_gnt", alloc_gnt_o, exp_gnt);
        ofs = 0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            check_eq($sformatf("alloc_preg%0d", i), alloc_preg_o[i], fl[(spec_off + ofs) % DEPTH]);
            ofs += req[i];
        end
        @(posedge clk);
        fired = (exp_gnt && rdy && !flv) ? ofs : 0;
        spec_off += fired;
        olds = '{o0, o1};
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (cv[j] && crv[j]) begin
                int n;
                int idx[$];
                n = fl.pop_front();
                fl.push_back(olds[j]);
                spec_off--;
                idx = pool.find_first_index(x) with (x == olds[j]);
                if (idx.size() > 0) pool.delete(idx[0]);
                pool.push_back(n);
            end
        end
        if (flv) spec_off = 0;
        #1;
    endtask

    initial begin
        do_reset();

        // Random traffic: reclaims only retire instructions that actually hold an allocation.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] req;
            logic [1:0] cv;
            logic [1:0] crv;
            logic       rdy;
            logic       flv;
            int         o[2];
            int         k;
            int         idx;
            req  = 2'($urandom);
            rdy  = ($urandom_range(3) != 0);
            flv  = ($urandom_range(15) == 0);
            cv   = 2'($urandom);
            crv  = 2'($urandom | $urandom);
            o[0] = $urandom_range(63);
            o[1] = $urandom_range(63);
            k    = 0;
            for (int j = 0; j < FREE_WIDTH; j++) begin
                if (cv[j] && crv[j]) begin
                    if (k < spec_off) begin
                        idx  = $urandom_range(pool.size() - 1);
                        o[j] = pool[idx];
                        pool.delete(idx);
                        k++;
                    end else begin
                        crv[j] = 1'b0;
                    end
                end
            end
            step(req, rdy, flv, cv, crv, o[0], o[1]);
        end

        // Reset contents and full drain to empty.
        do_reset();
        alloc_req_i = 2'b11;
        #1;
        check_eq("rst_gnt", alloc_gnt_o, 1);
        check_eq("rst_cnt", free_cnt_o, 32);
        check_eq("rst_preg0", alloc_preg_o[0], 32);
        check_eq("rst_preg1", alloc_preg_o[1], 33);
        for (int c = 0; c < 16; c++) step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("drain_cnt", free_cnt_o, 0);
        check_eq("drain_gnt", alloc_gnt_o, 0);
        step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("empty_hold_cnt", free_cnt_o, 0);
        check_eq("empty_hold_preg0", alloc_preg_o[0], 32);

        // Single request on slot 1 takes the head entry.
        do_reset();
        step(2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("slot1_cnt", free_cnt_o, 31);
        check_eq("slot1_next", alloc_preg_o[1], 33);

        // Reclaimed pregs come back after 63 once the list wraps.
        do_reset();
        step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        step(2'b00, 1'b1, 1'b0, 2'b11, 2'b11, 5, 7);
        check_eq("reclaim_cnt", free_cnt_o, 30);
        for (int c = 0; c < 14; c++) step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("wrap_cnt", free_cnt_o, 2);
        alloc_req_i = 2'b11;
        #1;
        check_eq("wrap_preg0", alloc_preg_o[0], 5);
        check_eq("wrap_preg1", alloc_preg_o[1], 7);
        step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);

        // Flush with same-cycle reclaim and a blocked allocation.
        do_reset();
        for (int c = 0; c < 3; c++) step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        step(2'b11, 1'b1, 1'b1, 2'b11, 2'b11, 1, 2);
        check_eq("flush_cnt", free_cnt_o, 32);
        check_eq("flush_preg0", alloc_preg_o[0], 34);
        check_eq("flush_preg1", alloc_preg_o[1], 35);
        step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);

        // One free entry blocks even a single request; reclaim restores the grant.
        do_reset();
        for (int c = 0; c < 15; c++) step(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        step(2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("one_left_cnt", free_cnt_o, 1);
        check_eq("one_left_gnt", alloc_gnt_o, 0);
        step(2'b01, 1'b1, 1'b0, 2'b11, 2'b11, 3, 4);
        check_eq("refill_cnt", free_cnt_o, 3);
        check_eq("refill_gnt", alloc_gnt_o, 1);

`ifdef FREELIST_CHECK_EN
        do_reset();
        check_eq("dbg_err_rst", dbg_err_o, 0);
        step(2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        check_eq("dbg_err_clean", dbg_err_o, 0);
        step(2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 40, 0);
        check_eq("dbg_err_set", dbg_err_o, 1);
        for (int c = 0; c < 3; c++) begin
            step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
            check_eq("dbg_err_sticky", dbg_err_o, 1);
        end
        do_reset();
        check_eq("dbg_err_cleared", dbg_err_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
